// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter, its three requesters and the single-port RAM.
// The arbiter uses the slave modport; the requester/RAM side uses master.
interface mem_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_ack;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_rdata;

  logic              busy;
  logic [1:0]        owner;

  modport slave (
    input  if_req, if_addr,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  ld_req, ld_addr, ld_wdata,
    input  ram_rdata,
    output if_rdata, if_ack, mem_rdata, mem_ack, ld_ack,
    output ram_addr, ram_wdata, ram_wren,
    output busy, owner
  );

  modport master (
    output if_req, if_addr,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output ld_req, ld_addr, ld_wdata,
    output ram_rdata,
    input  if_rdata, if_ack, mem_rdata, mem_ack, ld_ack,
    input  ram_addr, ram_wdata, ram_wren,
    input  busy, owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// Three-way arbiter onto one single-port RAM: loader has absolute priority,
// instruction fetch and load/store alternate on ties. One transaction every 4 cycles.
module mem_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP, DONE} state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_MEM  = 2'd2;
  localparam logic [1:0] OWN_LD   = 2'd3;

  state_t            state;
  logic              wflag;
  logic              mem_last;
  logic              grant;
  logic [1:0]        sel_owner;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;

  // mem_last remembers whether MEM or IF won the most recent IF/MEM grant
  always_comb begin
    grant     = 1'b1;
    sel_owner = OWN_NONE;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    if (bus.ld_req) begin
      sel_owner = OWN_LD;
      sel_addr  = bus.ld_addr;
      sel_wdata = bus.ld_wdata;
      sel_we    = 1'b1;
    end else if (bus.mem_req && (!bus.if_req || !mem_last)) begin
      sel_owner = OWN_MEM;
      sel_addr  = bus.mem_addr;
      sel_wdata = bus.mem_wdata;
      sel_we    = bus.mem_we;
    end else if (bus.if_req) begin
      sel_owner = OWN_IF;
      sel_addr  = bus.if_addr;
    end else begin
      grant = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      wflag         <= 1'b0;
      mem_last      <= 1'b0;
      bus.owner     <= OWN_NONE;
      bus.busy      <= 1'b0;
      bus.if_ack    <= 1'b0;
      bus.mem_ack   <= 1'b0;
      bus.ld_ack    <= 1'b0;
      bus.ram_wren  <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
      bus.if_rdata  <= '0;
      bus.mem_rdata <= '0;
    end else begin
      bus.if_ack  <= 1'b0;
      bus.mem_ack <= 1'b0;
      bus.ld_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            state         <= ACCESS;
            bus.owner     <= sel_owner;
            bus.busy      <= 1'b1;
            bus.ram_addr  <= sel_addr;
            bus.ram_wdata <= sel_wdata;
            bus.ram_wren  <= sel_we;
            wflag         <= sel_we;
            if (sel_owner == OWN_MEM) mem_last <= 1'b1;
            else if (sel_owner == OWN_IF) mem_last <= 1'b0;
          end
        end
        ACCESS: begin
          state        <= RESP;
          bus.ram_wren <= 1'b0;
        end
        RESP: begin
          state <= DONE;
          // RAM data is valid now, one cycle after the address was presented
          if (!wflag && bus.owner == OWN_IF)  bus.if_rdata  <= bus.ram_rdata;
          if (!wflag && bus.owner == OWN_MEM) bus.mem_rdata <= bus.ram_rdata;
          case (bus.owner)
            OWN_IF:  bus.if_ack  <= 1'b1;
            OWN_MEM: bus.mem_ack <= 1'b1;
            OWN_LD:  bus.ld_ack  <= 1'b1;
            default: ;
          endcase
        end
        DONE: begin
          state     <= IDLE;
          bus.owner <= OWN_NONE;
          bus.busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
